// File: rtl/action_executor_pkg.sv
// Shared definitions for the action path: click codes produced by the click
// detector and the executor FSM state encoding.
//   Action codes : NONE, BTNC (single centre), DBLBTNC (double centre),
//                  UNUSED_CODE, U, R, D, L
//   exec_state_e : IDLE, CMD, ACKS, RELEASE
package action_executor_pkg;

  localparam logic [2:0] NONE        = 3'b000;
  localparam logic [2:0] BTNC        = 3'b001;
  localparam logic [2:0] DBLBTNC     = 3'b010;
  localparam logic [2:0] UNUSED_CODE = 3'b011;
  localparam logic [2:0] U           = 3'b100;
  localparam logic [2:0] R           = 3'b101;
  localparam logic [2:0] D           = 3'b110;
  localparam logic [2:0] L           = 3'b111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMD     = 2'd1,
    ACKS    = 2'd2,
    RELEASE = 2'd3
  } exec_state_e;

  // All direction codes have the MSB set; centre clicks and NONE do not.
  function automatic logic is_move(input logic [2:0] code);
    return code[2];
  endfunction

endpackage

// File: rtl/action_executor_cursor_wrap_counter.sv
// One cursor axis: a counter over 0..MAX that wraps in both directions.
// Ports:
//   clk   - clock
//   clear - synchronous active-high reset to 0
//   inc   - step +1 (MAX wraps to 0)
//   dec   - step -1 (0 wraps to MAX)
//   value - current position
// inc and dec together are treated as no step.
module cursor_wrap_counter #(
  parameter int MAX = 7,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] value
);

  localparam logic [W-1:0] TOP = W'(MAX);

  always_ff @(posedge clk) begin
    if (clear) begin
      value <= '0;
    end else if (inc && !dec) begin
      value <= (value == TOP) ? '0 : value + W'(1);
    end else if (dec && !inc) begin
      value <= (value == '0) ? TOP : value - W'(1);
    end
  end

endmodule

// File: rtl/action_executor.sv
// Turns click codes into cursor moves and board commands.
// Ports:
//   clk, clear            - clock, synchronous active-high reset
//   Action[2:0]           - click code from the click detector
//   game_over             - suppresses reveal/flag commands
//   cmd_ready             - board controller accepts the pending command
//   ACK                   - one-cycle pulse that clears the click detector
//   cmd_valid, cmd_flag   - board command (flag: 0 reveal, 1 toggle flag)
//   cursor_row/cursor_col - cursor position
//   busy                  - FSM not in IDLE
// Command handshake: cmd_valid rises when a command is issued and stays high,
// with cmd_flag and the cursor frozen, until an edge where cmd_ready is also
// high; that edge transfers the command. A raised cmd_valid is never dropped
// except by clear.
// Every output is either a register or a decode of the state register, so
// there is no combinational path from Action to any output.
module action_executor
  import action_executor_pkg::*;
#(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int ROW_W = 3,
  parameter int COL_W = 3
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [2:0]       Action,
  input  logic             game_over,
  input  logic             cmd_ready,
  output logic             ACK,
  output logic             cmd_valid,
  output logic             cmd_flag,
  output logic [ROW_W-1:0] cursor_row,
  output logic [COL_W-1:0] cursor_col,
  output logic             busy
);

  exec_state_e state, next_state;
  logic        row_inc, row_dec, col_inc, col_dec;
  logic        load_flag;

  always_ff @(posedge clk) begin
    if (clear) begin
      state    <= IDLE;
      cmd_flag <= 1'b0;
    end else begin
      state <= next_state;
      if (load_flag) cmd_flag <= (Action == DBLBTNC);
    end
  end

  always_comb begin
    next_state = state;
    row_inc    = 1'b0;
    row_dec    = 1'b0;
    col_inc    = 1'b0;
    col_dec    = 1'b0;
    load_flag  = 1'b0;
    case (state)
      IDLE: begin
        if (Action != NONE) begin
          if (is_move(Action)) begin
            row_inc    = (Action == D);
            row_dec    = (Action == U);
            col_inc    = (Action == R);
            col_dec    = (Action == L);
            next_state = ACKS;
          end else if ((Action == BTNC || Action == DBLBTNC) && !game_over) begin
            load_flag  = 1'b1;
            next_state = CMD;
          end else begin
            // Suppressed centre click or unused code: acknowledge only.
            next_state = ACKS;
          end
        end
      end
      CMD:     if (cmd_ready) next_state = ACKS;
      ACKS:    next_state = RELEASE;
      // Wait for the detector to report NONE so a held code runs only once.
      RELEASE: if (Action == NONE) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign ACK       = (state == ACKS);
  assign cmd_valid = (state == CMD);
  assign busy      = (state != IDLE);

  cursor_wrap_counter #(.MAX(ROWS - 1), .W(ROW_W)) u_row (
    .clk   (clk),
    .clear (clear),
    .inc   (row_inc),
    .dec   (row_dec),
    .value (cursor_row)
  );

  cursor_wrap_counter #(.MAX(COLS - 1), .W(COL_W)) u_col (
    .clk   (clk),
    .clear (clear),
    .inc   (col_inc),
    .dec   (col_dec),
    .value (cursor_col)
  );

endmodule

// File: tb/tb_action_executor.sv
// Bench for action_executor: directed presses, expected ACK cursors and
// command contents queued at issue time, checked by an independent monitor.
module tb_action_executor;
  import action_executor_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       clear;
  logic [2:0] act;
  logic       game_over;
  logic       cmd_ready;

  logic       ACK, cmd_valid, cmd_flag, busy;
  logic [2:0] cursor_row, cursor_col;
  logic       ACK_5, cmd_valid_5, cmd_flag_5, busy_5;
  logic [2:0] cursor_row_5, cursor_col_5;

  always #5 clk = ~clk;

  action_executor dut (
    .clk(clk), .clear(clear), .Action(act), .game_over(game_over),
    .cmd_ready(cmd_ready), .ACK(ACK), .cmd_valid(cmd_valid),
    .cmd_flag(cmd_flag), .cursor_row(cursor_row), .cursor_col(cursor_col),
    .busy(busy)
  );

  action_executor #(.ROWS(5), .COLS(8), .ROW_W(3), .COL_W(3)) dut5 (
    .clk(clk), .clear(clear), .Action(act), .game_over(game_over),
    .cmd_ready(cmd_ready), .ACK(ACK_5), .cmd_valid(cmd_valid_5),
    .cmd_flag(cmd_flag_5), .cursor_row(cursor_row_5),
    .cursor_col(cursor_col_5), .busy(busy_5)
  );

  // ---------------- scoreboard ----------------
  int vectors     = 0;
  int miscompares = 0;
  logic [5:0] ack_q[$];   // {row, col} expected at each ACK
  logic [6:0] cmd_q[$];   // {flag, row, col} expected at each handshake
  int m_row = 0;
  int m_col = 0;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: inputs change on negedges, so sample just after one.
  initial begin
    logic [5:0] ea;
    logic [6:0] ec;
    forever begin
      @(negedge clk);
      #1;
      if (ACK === 1'b1) begin
        if (ack_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL ack_unexpected: got ACK=1 expected none at %0t", $time);
        end else begin
          ea = ack_q.pop_front();
          check("ack_cursor", 32'({cursor_row, cursor_col}), 32'(ea));
        end
      end
      if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
        if (cmd_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL cmd_unexpected: got handshake expected none at %0t", $time);
        end else begin
          ec = cmd_q.pop_front();
          check("cmd_content", 32'({cmd_flag, cursor_row, cursor_col}), 32'(ec));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("busy_returns_idle", 32'(busy), 32'(0));
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    act   = NONE;
    @(negedge clk);
    clear = 1'b0;
    m_row = 0;
    m_col = 0;
  endtask

  // Apply a code for 'hold' cycles, then release it and wait for IDLE.
  task automatic press(input logic [2:0] code, input int hold);
    logic is_cmd;
    int   elapsed;
    is_cmd = (code == BTNC || code == DBLBTNC) && !game_over;
    case (code)
      U: m_row = (m_row == 0) ? 7 : m_row - 1;
      D: m_row = (m_row == 7) ? 0 : m_row + 1;
      L: m_col = (m_col == 0) ? 7 : m_col - 1;
      R: m_col = (m_col == 7) ? 0 : m_col + 1;
      default: ;
    endcase
    if (is_cmd) cmd_q.push_back({code == DBLBTNC, 3'(m_row), 3'(m_col)});
    ack_q.push_back({3'(m_row), 3'(m_col)});
    @(negedge clk);
    act = code;
    @(negedge clk);
    elapsed = 1;
    if (is_cmd) begin
      check("cmd_valid_first", 32'(cmd_valid), 32'(1));
      check("cmd_flag_first", 32'(cmd_flag), 32'(code == DBLBTNC));
      if (cmd_ready) begin
        @(negedge clk);
        elapsed++;
        check("cmd_to_ack_lat2", 32'(ACK), 32'(1));
      end
    end else begin
      check("ack_lat1", 32'(ACK), 32'(1));
      check("no_cmd_valid", 32'(cmd_valid), 32'(0));
    end
    while (elapsed < hold) begin
      @(negedge clk);
      elapsed++;
    end
    act = NONE;
    wait_idle();
  endtask

  // ---------------- stimulus ----------------
  logic [2:0] exp5 [8];

  initial begin
    exp5 = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd2, 3'd3};
    clear = 1'b1; act = NONE; game_over = 1'b0; cmd_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(ACK), 32'(0));
    check("rst_cmd_valid", 32'(cmd_valid), 32'(0));
    check("rst_cmd_flag", 32'(cmd_flag), 32'(0));
    check("rst_cursor", 32'({cursor_row, cursor_col}), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    clear = 1'b0;

    // Idle with NONE holds everything.
    repeat (3) @(negedge clk);
    check("idle_hold", 32'({busy, cursor_row, cursor_col}), 32'(0));

    // D held for 3 cycles: one move, one ACK.
    press(D, 3);
    check("held_d_row", 32'(cursor_row), 32'(1));

    // Wrap at the edges.
    do_clear();
    press(U, 1);
    check("wrap_u_row", 32'(cursor_row), 32'(7));
    for (int i = 0; i < 7; i++) press(R, 1);
    check("col_at_7", 32'(cursor_col), 32'(7));
    press(R, 1);
    check("wrap_r_col", 32'(cursor_col), 32'(0));
    press(L, 2);
    check("wrap_l_col", 32'(cursor_col), 32'(7));
    press(D, 1);
    check("wrap_d_row", 32'(cursor_row), 32'(0));
    press(D, 1);
    press(L, 1);

    // Commands with cmd_ready already high.
    press(BTNC, 1);
    press(DBLBTNC, 2);

    // Flag command with cmd_ready low for 4 cycles; Action and game_over
    // changes during CMD are ignored.
    cmd_ready = 1'b0;
    cmd_q.push_back({1'b1, 3'(m_row), 3'(m_col)});
    ack_q.push_back({3'(m_row), 3'(m_col)});
    @(negedge clk);
    act = DBLBTNC;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(cmd_valid), 32'(1));
      check("stall_flag", 32'(cmd_flag), 32'(1));
      check("stall_cursor", 32'({cursor_row, cursor_col}),
            32'({3'(m_row), 3'(m_col)}));
      check("stall_no_ack", 32'(ACK), 32'(0));
      if (i == 1) act = R;
      if (i == 2) game_over = 1'b1;
      if (i == 3) act = NONE;
      if (i == 4) cmd_ready = 1'b1;
    end
    @(negedge clk);
    check("stall_ack", 32'(ACK), 32'(1));
    check("stall_valid_drop", 32'(cmd_valid), 32'(0));
    wait_idle();

    // Suppressed commands and the unused code: ACK only.
    press(BTNC, 1);
    press(DBLBTNC, 1);
    game_over = 1'b0;
    press(UNUSED_CODE, 1);

    // Clear while a command is pending.
    cmd_ready = 1'b0;
    @(negedge clk);
    act = BTNC;
    @(negedge clk);
    check("pre_clear_valid", 32'(cmd_valid), 32'(1));
    act   = NONE;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_row = 0;
    m_col = 0;
    check("clr_cmd_valid", 32'(cmd_valid), 32'(0));
    check("clr_ack", 32'(ACK), 32'(0));
    check("clr_cursor", 32'({cursor_row, cursor_col}), 32'(0));
    check("clr_busy_flag", 32'({busy, cmd_flag}), 32'(0));
    cmd_ready = 1'b1;
    // First action after clear is taken straight from IDLE.
    press(R, 1);
    check("post_clear_col", 32'(cursor_col), 32'(1));

    // Five-row board: eight D presses.
    do_clear();
    for (int i = 0; i < 8; i++) begin
      press(D, 1);
      check("rows5_seq", 32'(cursor_row_5), 32'(exp5[i]));
    end

    repeat (3) @(negedge clk);
    check("ack_q_drained", 32'(ack_q.size()), 32'(0));
    check("cmd_q_drained", 32'(cmd_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
